// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter
//
// Purpose:
//   Shares one RMII transmit dibit stream between two frame sources. One
//   source is granted per frame using round-robin. The granted source's
//   dibits are forwarded with one cycle of latency. A frame ends when the
//   granted source drops valid. After every forwarded frame the block holds
//   the Ethernet inter-frame gap before it grants again. Frames that exceed
//   the maximum length are truncated. Grants whose owner never starts
//   sending are revoked after a timeout.
//
// Ports:
//   clk            system clock (50 MHz RMII domain)
//   rst            asynchronous, active-high reset
//   req0 / req1    source requests the stream; held high until frame end
//   axiiv0/axiiv1  source dibit valid
//   axiid0/axiid1  source dibit
//   gnt0 / gnt1    source owns the stream (never both high)
//   axiov          output dibit valid (registered)
//   axiod          output dibit (registered)
//   busy           high in every state except IDLE
//   abort          one-cycle pulse when a frame is cut at MAX_FRAME_DIBITS
// ---------------------------------------------------------------------------
module eth_tx_arbiter #(
  parameter int IFG_DIBITS       = 48,
  parameter int MAX_FRAME_DIBITS = 6104,
  parameter int START_TIMEOUT    = 64,
  parameter int DATA_W           = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              axiiv0,
  input  logic [DATA_W-1:0] axiid0,
  input  logic              req1,
  input  logic              axiiv1,
  input  logic [DATA_W-1:0] axiid1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              axiov,
  output logic [DATA_W-1:0] axiod,
  output logic              busy,
  output logic              abort
);

  localparam int FW = $clog2(MAX_FRAME_DIBITS + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(IFG_DIBITS + 1);

  localparam logic [FW-1:0] FRAME_LAST = FW'(MAX_FRAME_DIBITS);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(IFG_DIBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // last_gnt doubles as the owner select while a grant is outstanding:
  // it is loaded at grant time and holds until the next grant.
  logic              last_gnt;
  logic              last_gnt_nxt;

  logic [FW-1:0]     frame_cnt;
  logic [FW-1:0]     frame_cnt_nxt;
  logic [TW-1:0]     start_cnt;
  logic [TW-1:0]     start_cnt_nxt;
  logic [GW-1:0]     gap_cnt;
  logic [GW-1:0]     gap_cnt_nxt;

  logic              gnt0_nxt;
  logic              gnt1_nxt;
  logic              axiov_nxt;
  logic [DATA_W-1:0] axiod_nxt;
  logic              busy_nxt;
  logic              abort_nxt;

  logic              pick;
  logic              sel_req;
  logic              sel_v;
  logic [DATA_W-1:0] sel_d;

  // Saturating increment shared by all counters: never wraps past limit.
  function automatic int sat_inc(input int value, input int limit);
    return (value >= limit) ? value : value + 1;
  endfunction

  // Only the owner's request/valid/data are ever looked at.
  assign sel_req = last_gnt ? req1   : req0;
  assign sel_v   = last_gnt ? axiiv1 : axiiv0;
  assign sel_d   = last_gnt ? axiid1 : axiid0;

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    last_gnt_nxt  = last_gnt;
    frame_cnt_nxt = frame_cnt;
    start_cnt_nxt = start_cnt;
    gap_cnt_nxt   = gap_cnt;
    gnt0_nxt      = gnt0;
    gnt1_nxt      = gnt1;
    axiov_nxt     = 1'b0;
    axiod_nxt     = '0;
    abort_nxt     = 1'b0;
    pick          = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // Under contention the source that did not win last time wins.
          pick          = (req0 && req1) ? ~last_gnt : req1;
          last_gnt_nxt  = pick;
          gnt0_nxt      = ~pick;
          gnt1_nxt      = pick;
          start_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end

      GRANT: begin
        if (sel_v) begin
          axiov_nxt     = 1'b1;
          axiod_nxt     = sel_d;
          frame_cnt_nxt = FW'(1);
          state_nxt     = XFER;
        end else if (!sel_req || (start_cnt == START_LAST)) begin
          // Owner withdrew or never started: release without a gap.
          gnt0_nxt  = 1'b0;
          gnt1_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          start_cnt_nxt = TW'(sat_inc(int'(start_cnt), START_TIMEOUT));
        end
      end

      XFER: begin
        if (!sel_v) begin
          gnt0_nxt    = 1'b0;
          gnt1_nxt    = 1'b0;
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
        end else if (frame_cnt == FRAME_LAST) begin
          // Frame already at the limit and still going: cut it here and
          // drop the rest of the source's dibits.
          abort_nxt   = 1'b1;
          gnt0_nxt    = 1'b0;
          gnt1_nxt    = 1'b0;
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
        end else begin
          axiov_nxt     = 1'b1;
          axiod_nxt     = sel_d;
          frame_cnt_nxt = FW'(sat_inc(int'(frame_cnt), MAX_FRAME_DIBITS));
        end
      end

      GAP: begin
        // Requests arriving now stay pending; IDLE picks them up.
        if (gap_cnt == GAP_LAST) begin
          frame_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          gap_cnt_nxt = GW'(sat_inc(int'(gap_cnt), IFG_DIBITS));
        end
      end

      default: begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      frame_cnt <= '0;
      start_cnt <= '0;
      gap_cnt   <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      axiov     <= 1'b0;
      axiod     <= '0;
      busy      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_gnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      start_cnt <= start_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      axiov     <= axiov_nxt;
      axiod     <= axiod_nxt;
      busy      <= busy_nxt;
      abort     <= abort_nxt;
    end
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single 2-bit RMII transmit stream between two frame sources, for example the firewall-forwarded path and a locally generated reply path.
- Grants one source per frame using round-robin and forwards that source's dibits with one cycle of latency.
- Enforces the Ethernet inter-frame gap and guards against runaway or never-starting frames.
- Sits directly upstream of the RMII TX serializer/CRC block.

Parameters:
IFG_DIBITS, 48, idle cycles forced between frames (96 bit times at 2 bits/cycle)
MAX_FRAME_DIBITS, 6104, longest legal frame in dibits (1526 bytes); a longer frame is aborted
START_TIMEOUT, 64, cycles a granted source may take to raise valid before the grant is revoked

Ports:
clk  in  1  system clock (50 MHz RMII domain)
rst  in  1  asynchronous, active-high reset
req0  in  1  source 0 requests the TX stream; held high until frame end
axiiv0  in  1  source 0 dibit valid
axiid0  in  2  source 0 dibit
req1  in  1  source 1 request
axiiv1  in  1  source 1 dibit valid
axiid1  in  2  source 1 dibit
gnt0  out  1  source 0 owns the stream
gnt1  out  1  source 1 owns the stream
axiov  out  1  output dibit valid
axiod  out  2  output dibit
busy  out  1  high in every state except IDLE
abort  out  1  one-cycle pulse when a frame is truncated at MAX_FRAME_DIBITS

Behaviour:
- One clock domain, clk; reset is asynchronous and active-high on rst.
- Reset values:
  - gnt0 = gnt1 = axiov = busy = abort = 0; axiod = 00.
  - State = IDLE; last_gnt = 1, so source 0 wins the first contention.
  - All counters = 0.
- Reset asserted mid-frame clears all outputs immediately (asynchronously). No partial-frame cleanup occurs.
- All outputs are registered. gnt0 and gnt1 are never high together.
- IDLE:
  - On an edge where any req is high: grant the requester; if both are high, grant the source != last_gnt.
  - gnt rises on that edge; go to GRANT; load last_gnt.
- GRANT:
  - Granted axiiv high at an edge → go to XFER. That dibit appears on axiod with axiov = 1 after that same edge (1-cycle latency).
  - Granted req falls before valid → drop gnt, return to IDLE, no gap.
  - START_TIMEOUT cycles elapse without valid → drop gnt, return to IDLE.
- XFER:
  - Each cycle: axiov <= granted axiiv; axiod <= granted axiid; increment the frame counter.
  - Granted axiiv sampled low → axiov = 0 and gnt = 0 on that edge; go to GAP.
  - Frame counter reaches MAX_FRAME_DIBITS while valid is still high:
    - axiov = 0, gnt = 0, abort = 1 for one cycle; go to GAP.
    - The source's remaining dibits are ignored.
- GAP:
  - Exactly IFG_DIBITS cycles with axiov = 0 and no grant; then IDLE.
  - Requests during GAP are held pending, not lost.
- Only the granted source's axiiv/axiid are observed. A non-granted source's valid is ignored and never reaches the output.
- A source's req dropping during XFER does not end the frame; only valid low ends it.
- Counters saturate at their limits and never wrap.
- Minimum output gap: from the last axiov = 1 of one frame to the first axiov = 1 of the next is ≥ IFG_DIBITS + 2 cycles.

Test Plan:
1. Single source: req0 = 1, source 0 sends 100 dibits of 01 after gnt0 → axiov high for exactly 100 cycles, axiod = 01, lagging input by 1 cycle; gnt1 never rises; busy falls 48 cycles after the frame ends.
2. Contention after reset: req0 = req1 = 1 together → gnt0 first. After frame 0 plus 48 idle cycles, gnt1 is granted. Next contention grants 0 again (alternation over 4 frames).
3. Ungranted noise: source 1 drives axiiv1 = 1, axiid1 = 11 continuously while source 0 owns the stream and sends 10s → axiod is only 10; no 11 appears on the output.
4. Start timeout: req1 = 1, source 1 never raises valid → gnt1 drops after 64 cycles and the block is IDLE the next cycle. A pending req0 is then granted.
5. Oversize frame: MAX_FRAME_DIBITS = 20, source 0 sends 30 dibits → exactly 20 output dibits; abort pulses once; gnt0 drops; 48-cycle gap follows.
6. Reset mid-frame: assert rst asynchronously at dibit 10 → gnt0, axiov and busy are 0 before the next edge. After release, the first contention grants source 0.
